// File: rtl/rk4_ctrl_pkg.sv
// Shared types and constants for the RK4 projectile run controller.
package rk4_ctrl_pkg;

   typedef logic signed [31:0] q16_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CALC,
      S_STEP,
      S_WAIT,
      S_SEND_T,
      S_SEND_Y,
      S_EOS,
      S_WDOG
   } state_t;

   localparam logic [31:0] EOS_MARKER          = 32'hDEAD_BEEF;
   localparam logic [31:0] WDOG_MARKER         = 32'hBADC_0DE0;
   localparam q16_t        DT_K_DEFAULT        = 32'sh0000_0086;
   localparam int          N_STEPS_DEFAULT     = 100;
   localparam int          WDOG_CYCLES_DEFAULT = 4096;

endpackage

// File: rtl/q16_mul.sv
// Combinational signed Q16.16 multiply: full 64-bit product, arithmetic shift by 16, low 32 bits kept.
module q16_mul
   import rk4_ctrl_pkg::*;
(
   input  q16_t a,
   input  q16_t b,
   output q16_t p
);

   logic signed [63:0] a_x;
   logic signed [63:0] b_x;

   assign a_x = {{32{a[31]}}, a};
   assign b_x = {{32{b[31]}}, b};
   assign p   = q16_t'((a_x * b_x) >>> 16);

endmodule

// File: rtl/rk4_run_controller.sv
// Sequences one projectile run: derives dt from v0y, steps the RK4 core, streams (t, y) pairs and EOS.
// Optional core_done watchdog enabled by defining RK4_WDOG_EN.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | waiting for a launch velocity
// S_CALC   | compute dt, seed t/y/vy, reject non-positive v0y
// S_STEP   | issue one core_start pulse
// S_WAIT   | core in flight, inputs held
// S_SEND_T | offer committed t to the serializer
// S_SEND_Y | offer committed y to the serializer
// S_EOS    | offer end-of-stream marker, then back to idle
// S_WDOG   | offer watchdog marker (core never answered), then EOS
module rk4_run_controller
   import rk4_ctrl_pkg::*;
#(
   parameter int   N_STEPS = N_STEPS_DEFAULT,
   parameter q16_t DT_K    = DT_K_DEFAULT
`ifdef RK4_WDOG_EN
   ,parameter int  WDOG_CYCLES = WDOG_CYCLES_DEFAULT
`endif
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        v0y_valid,
   input  logic [31:0] v0y_data,
   output logic        busy,
   output logic        core_start,
   output logic [31:0] core_dt,
   output logic [31:0] core_t,
   output logic [31:0] core_y,
   output logic [31:0] core_vy,
   input  logic        core_done,
   input  logic [31:0] core_t_out,
   input  logic [31:0] core_y_out,
   input  logic [31:0] core_vy_out,
   output logic        tx_valid,
   output logic [31:0] tx_data,
   input  logic        tx_ready,
   output logic [7:0]  step_cnt
);

   state_t      state, state_nxt;
   q16_t        v0y_q, v0y_nxt;
   q16_t        dt_prod;
   logic        busy_nxt, start_nxt, valid_nxt;
   logic [31:0] dt_nxt, t_nxt, y_nxt, vy_nxt, data_nxt;
   logic [7:0]  cnt_nxt;
`ifdef RK4_WDOG_EN
   logic [31:0] wdog_cnt, wdog_nxt;
`endif

   q16_mul u_dt_mul (
      .a (v0y_q),
      .b (DT_K),
      .p (dt_prod)
   );

   always_comb begin
      state_nxt = state;
      v0y_nxt   = v0y_q;
      busy_nxt  = busy;
      start_nxt = 1'b0;
      dt_nxt    = core_dt;
      t_nxt     = core_t;
      y_nxt     = core_y;
      vy_nxt    = core_vy;
      valid_nxt = tx_valid;
      data_nxt  = tx_data;
      cnt_nxt   = step_cnt;
`ifdef RK4_WDOG_EN
      wdog_nxt  = wdog_cnt;
`endif
      case (state)
         S_IDLE: begin
            if (v0y_valid) begin
               v0y_nxt   = q16_t'(v0y_data);
               busy_nxt  = 1'b1;
               state_nxt = S_CALC;
            end
         end
         S_CALC: begin
            dt_nxt  = dt_prod;
            t_nxt   = '0;
            y_nxt   = '0;
            vy_nxt  = v0y_q;
            cnt_nxt = '0;
            if (v0y_q[31] || (v0y_q == '0)) begin
               state_nxt = S_EOS;
               valid_nxt = 1'b1;
               data_nxt  = EOS_MARKER;
            end else begin
               state_nxt = S_STEP;
            end
         end
         S_STEP: begin
            start_nxt = 1'b1;
            state_nxt = S_WAIT;
`ifdef RK4_WDOG_EN
            wdog_nxt  = 32'(WDOG_CYCLES - 1);
`endif
         end
         S_WAIT: begin
            if (core_done) begin
               cnt_nxt   = step_cnt + 8'd1;
               valid_nxt = 1'b1;
               // A step that lands below ground is counted but never committed or sent.
               if (core_y_out[31]) begin
                  state_nxt = S_EOS;
                  data_nxt  = EOS_MARKER;
               end else begin
                  t_nxt     = core_t_out;
                  y_nxt     = core_y_out;
                  vy_nxt    = core_vy_out;
                  state_nxt = S_SEND_T;
                  data_nxt  = core_t_out;
               end
            end
`ifdef RK4_WDOG_EN
            else if (wdog_cnt == '0) begin
               state_nxt = S_WDOG;
               valid_nxt = 1'b1;
               data_nxt  = WDOG_MARKER;
            end else begin
               wdog_nxt  = wdog_cnt - 32'd1;
            end
`endif
         end
         S_SEND_T: begin
            if (tx_ready) begin
               state_nxt = S_SEND_Y;
               data_nxt  = core_y;
            end
         end
         S_SEND_Y: begin
            if (tx_ready) begin
               if (step_cnt == 8'(N_STEPS)) begin
                  state_nxt = S_EOS;
                  data_nxt  = EOS_MARKER;
               end else begin
                  state_nxt = S_STEP;
                  valid_nxt = 1'b0;
               end
            end
         end
         S_WDOG: begin
            if (tx_ready) begin
               state_nxt = S_EOS;
               data_nxt  = EOS_MARKER;
            end
         end
         S_EOS: begin
            if (tx_ready) begin
               state_nxt = S_IDLE;
               valid_nxt = 1'b0;
               busy_nxt  = 1'b0;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         v0y_q      <= '0;
         busy       <= 1'b0;
         core_start <= 1'b0;
         core_dt    <= '0;
         core_t     <= '0;
         core_y     <= '0;
         core_vy    <= '0;
         tx_valid   <= 1'b0;
         tx_data    <= '0;
         step_cnt   <= '0;
`ifdef RK4_WDOG_EN
         wdog_cnt   <= '0;
`endif
      end else begin
         state      <= state_nxt;
         v0y_q      <= v0y_nxt;
         busy       <= busy_nxt;
         core_start <= start_nxt;
         core_dt    <= dt_nxt;
         core_t     <= t_nxt;
         core_y     <= y_nxt;
         core_vy    <= vy_nxt;
         tx_valid   <= valid_nxt;
         tx_data    <= data_nxt;
         step_cnt   <= cnt_nxt;
`ifdef RK4_WDOG_EN
         wdog_cnt   <= wdog_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_rk4_run_controller.sv
// Bench for rk4_run_controller: Euler-style core model, word-stream scoreboard and directed runs.
`timescale 1ns/1ps
module tb_rk4_run_controller;
   import rk4_ctrl_pkg::*;

   localparam int   N_STEPS = 100;
   localparam q16_t DT_K    = 32'sh0000_0086;
   localparam q16_t G_Q     = 32'sh0009_CCCD;
`ifdef RK4_WDOG_EN
   localparam int   WDOG_CYCLES = 4096;
`endif

   logic        clk;
   logic        rst_n;
   logic        v0y_valid;
   logic [31:0] v0y_data;
   logic        busy;
   logic        core_start;
   logic [31:0] core_dt, core_t, core_y, core_vy;
   logic        core_done;
   logic [31:0] core_t_out, core_y_out, core_vy_out;
   logic        tx_valid;
   logic [31:0] tx_data;
   logic        tx_ready;
   logic [7:0]  step_cnt;

   rk4_run_controller dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .v0y_valid   (v0y_valid),
      .v0y_data    (v0y_data),
      .busy        (busy),
      .core_start  (core_start),
      .core_dt     (core_dt),
      .core_t      (core_t),
      .core_y      (core_y),
      .core_vy     (core_vy),
      .core_done   (core_done),
      .core_t_out  (core_t_out),
      .core_y_out  (core_y_out),
      .core_vy_out (core_vy_out),
      .tx_valid    (tx_valid),
      .tx_data     (tx_data),
      .tx_ready    (tx_ready),
      .step_cnt    (step_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // scoreboard: expected word stream and step_cnt at each handshake
   logic [31:0] exp_q[$];
   logic [7:0]  exp_sc[$];
   q16_t        exp_dt = '0;
   int          exp_steps = 0;

   int          run_words = 0, run_starts = 0, base_words = 0, base_starts = 0;
   int          run_id = 0, cur_id = 0;
   logic [31:0] first_word = '0;
   logic        prev_stall = 1'b0, prev_start = 1'b0;
   logic [31:0] prev_data = '0;

   int   start_cnt = 0, hold_step = -1, fail_at = -1, core_lat = 2;
   logic bp_en = 1'b0, spur_req = 1'b0;
   q16_t r_t, r_y, r_vy;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   // projectile step as the core computes it: forward Euler on y and vy
   task automatic core_fn(input q16_t t, input q16_t y, input q16_t vy, input q16_t dt,
                          input logic force_neg, output q16_t tn, output q16_t yn, output q16_t vyn);
      tn  = t + dt;
      yn  = force_neg ? q16_t'(-1) : q16_t'(longint'(y) + ((longint'(vy) * longint'(dt)) >>> 16));
      vyn = q16_t'(longint'(vy) - ((longint'(G_Q) * longint'(dt)) >>> 16));
   endtask

   task automatic build_model(input q16_t v0y, input int fail_step);
      q16_t t, y, vy, tn, yn, vyn;
      exp_q.delete();
      exp_sc.delete();
      exp_dt    = q16_t'((longint'(v0y) * longint'(DT_K)) >>> 16);
      exp_steps = 0;
      if (v0y > 0) begin
         t = '0; y = '0; vy = v0y;
         for (int k = 1; k <= N_STEPS; k++) begin
            core_fn(t, y, vy, exp_dt, (k == fail_step), tn, yn, vyn);
            exp_steps = k;
            if (yn[31]) break;
            t = tn; y = yn; vy = vyn;
            exp_q.push_back(t); exp_sc.push_back(8'(k));
            exp_q.push_back(y); exp_sc.push_back(8'(k));
         end
      end
      exp_q.push_back(EOS_MARKER);
      exp_sc.push_back(8'(exp_steps));
   endtask

   // compare process
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 1'b0;
         prev_start = 1'b0;
      end else begin
         if (prev_stall) begin
            check("tx_hold_valid", {31'b0, tx_valid}, 32'd1);
            check("tx_hold_data", tx_data, prev_data);
         end
         if (core_start) begin
            run_starts++;
            check("core_start_width", {31'b0, prev_start}, 32'd0);
            check("core_dt", core_dt, exp_dt);
         end
         if (tx_valid && tx_ready) begin
            if (cur_id != run_id) begin
               cur_id     = run_id;
               first_word = tx_data;
            end
            run_words++;
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL tx_extra: got %08h expected no word", tx_data);
            end else begin
               check("tx_word", tx_data, exp_q.pop_front());
               check("tx_step_cnt", {24'b0, step_cnt}, {24'b0, exp_sc.pop_front()});
            end
         end
         prev_stall = tx_valid && !tx_ready;
         prev_data  = tx_data;
         prev_start = core_start;
      end
   end

   // RK4 core model
   initial begin
      core_done = 1'b0; core_t_out = '0; core_y_out = '0; core_vy_out = '0;
      forever begin
         @(posedge clk); #1;
         if (rst_n && core_start) begin
            start_cnt++;
            if (start_cnt != hold_step) begin
               core_fn(core_t, core_y, core_vy, core_dt, (start_cnt == fail_at), r_t, r_y, r_vy);
               repeat (core_lat - 1) @(posedge clk);
               #1;
               core_done = 1'b1; core_t_out = r_t; core_y_out = r_y; core_vy_out = r_vy;
               @(posedge clk); #1;
               core_done = 1'b0;
            end
         end else if (spur_req) begin
            core_done = 1'b1; core_t_out = 32'h0000_1234; core_y_out = 32'h0000_5678; core_vy_out = 32'h1;
            @(posedge clk); #1;
            core_done = 1'b0;
         end
      end
   end

   // serializer readiness
   initial begin
      tx_ready = 1'b1;
      forever begin
         @(posedge clk); #2;
         tx_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   task automatic check_reset(input string tag);
      check({tag, "_busy"},       {31'b0, busy}, 32'd0);
      check({tag, "_core_start"}, {31'b0, core_start}, 32'd0);
      check({tag, "_tx_valid"},   {31'b0, tx_valid}, 32'd0);
      check({tag, "_core_dt"},    core_dt, 32'd0);
      check({tag, "_core_t"},     core_t, 32'd0);
      check({tag, "_core_y"},     core_y, 32'd0);
      check({tag, "_core_vy"},    core_vy, 32'd0);
      check({tag, "_tx_data"},    tx_data, 32'd0);
      check({tag, "_step_cnt"},   {24'b0, step_cnt}, 32'd0);
   endtask

   task automatic start_run(input q16_t v0y, input int fail_step, input int hold);
      build_model(v0y, fail_step);
      run_id++;
      base_words  = run_words;
      base_starts = run_starts;
      fail_at     = start_cnt + fail_step;
      hold_step   = (hold > 0) ? start_cnt + hold : -1;
      @(negedge clk);
      v0y_valid = 1'b1;
      v0y_data  = v0y;
      @(negedge clk);
      v0y_valid = 1'b0;
      check("busy_rise", {31'b0, busy}, 32'd1);
      if (v0y > 0) begin
         @(negedge clk);
         check("start_lat2", {31'b0, core_start}, 32'd0);
         check("calc_step_cnt", {24'b0, step_cnt}, 32'd0);
         check("calc_vy", core_vy, v0y);
         @(negedge clk);
         check("start_lat3", {31'b0, core_start}, 32'd1);
      end
   endtask

   task automatic finish_run(input string name);
      int n = 0;
      while (busy && n < 20000) begin
         @(negedge clk);
         n++;
      end
      check({name, "_done_in_budget"}, {31'b0, busy}, 32'd0);
      @(negedge clk);
      check({name, "_words_left"}, exp_q.size(), 32'd0);
      check({name, "_idle_valid"}, {31'b0, tx_valid}, 32'd0);
      check({name, "_starts"}, run_starts - base_starts, exp_steps);
      check({name, "_step_cnt"}, {24'b0, step_cnt}, exp_steps);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation still running");
      $fatal(1);
   end

   initial begin
      int n;
      rst_n = 1'b0; v0y_valid = 1'b0; v0y_data = '0;
      repeat (3) @(negedge clk);
      check_reset("por");
      rst_n = 1'b1;
      @(negedge clk);

      // core_done while idle must be ignored
      spur_req = 1'b1;
      @(negedge clk);
      spur_req = 1'b0;
      repeat (3) @(negedge clk);
      check("spur_core_t", core_t, 32'd0);
      check("spur_busy", {31'b0, busy}, 32'd0);
      check("spur_tx_valid", {31'b0, tx_valid}, 32'd0);

      // 49.0 m/s: full 100-step run
      start_run(32'sh0031_0000, 0, 0);
      finish_run("v49");
      check("v49_dt_lit", core_dt, 32'h0000_19A6);
      check("v49_first_lit", first_word, 32'h0000_19A6);
      check("v49_words_lit", run_words - base_words, 32'd201);
      check("v49_steps_lit", {24'b0, step_cnt}, 32'd100);

      // 19.6 m/s with slower core
      core_lat = 3;
      start_run(32'sh0013_9999, 0, 0);
      finish_run("v19");
      check("v19_dt_lit", core_dt, 32'h0000_0A42);
      check("v19_first_lit", first_word, 32'h0000_0A42);
      core_lat = 2;

      // non-positive launch: EOS only
      start_run(32'shFFFF_0000, 0, 0);
      finish_run("vneg");
      check("vneg_first_lit", first_word, 32'hDEAD_BEEF);
      check("vneg_words_lit", run_words - base_words, 32'd1);
      start_run(32'sh0000_0000, 0, 0);
      finish_run("vzero");
      check("vzero_words_lit", run_words - base_words, 32'd1);

      // 9.8 m/s under random backpressure, stray v0y_valid mid-run
      bp_en = 1'b1;
      start_run(32'sh0009_CCCC, 0, 0);
      repeat (20) @(negedge clk);
      v0y_valid = 1'b1; v0y_data = 32'h0031_0000;
      @(negedge clk);
      v0y_valid = 1'b0;
      finish_run("v9_bp");
      check("v9_dt_lit", core_dt, 32'h0000_0521);
      bp_en = 1'b0;
      @(negedge clk);

      // ground hit forced on step 7
      start_run(32'sh0013_9999, 7, 0);
      finish_run("hit7");
      check("hit7_words_lit", run_words - base_words, 32'd13);
      check("hit7_steps_lit", {24'b0, step_cnt}, 32'd7);
      check("hit7_t_lit", core_t, 32'h0000_3D8C);

      // reset while waiting on step 40
      start_run(32'sh0031_0000, 0, 40);
      n = 0;
      while (start_cnt < hold_step && n < 20000) begin
         @(negedge clk);
         n++;
      end
      check("rst_reach_step40", {31'b0, start_cnt == hold_step}, 32'd1);
      repeat (3) @(negedge clk);
      check("rst_pre_step_cnt", {24'b0, step_cnt}, 32'd39);
      #2 rst_n = 1'b0;
      #1 check_reset("wait_rst");
      exp_q.delete();
      exp_sc.delete();
      hold_step = -1;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      start_run(32'sh0031_0000, 0, 0);
      finish_run("v49_again");
      check("v49b_first_lit", first_word, 32'h0000_19A6);
      check("v49b_steps_lit", {24'b0, step_cnt}, 32'd100);

`ifdef RK4_WDOG_EN
      // core never answers: watchdog marker then EOS
      start_run(32'sh0031_0000, 0, 1);
      exp_q.delete(); exp_sc.delete();
      exp_q.push_back(WDOG_MARKER); exp_sc.push_back(8'd0);
      exp_q.push_back(EOS_MARKER);  exp_sc.push_back(8'd0);
      n = 0;
      while (!tx_valid && n < 3 * WDOG_CYCLES) begin
         @(negedge clk);
         n++;
      end
      check("wdog_delay", {31'b0, (n >= WDOG_CYCLES - 2) && (n <= WDOG_CYCLES + 2)}, 32'd1);
      n = 0;
      while (busy && n < 100) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      check("wdog_words_left", exp_q.size(), 32'd0);
      check("wdog_words_lit", run_words - base_words, 32'd2);
      check("wdog_starts_lit", run_starts - base_starts, 32'd1);
      check("wdog_busy", {31'b0, busy}, 32'd0);
      hold_step = -1;
`endif

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/rk4_run_controller.md
Name: rk4_run_controller

Overview:
Sequences one projectile run of the RK4 step core inside the projectile top level. It accepts a launch velocity word from the UART RX word assembler and derives dt with a single Q16.16 multiply. It drives the RK4 core one step at a time, streams each (ti, yi) word pair to the UART TX word serializer, and terminates every run with the 0xDEADBEEF end-of-stream marker.

Parameters:
N_STEPS, 100, maximum RK4 steps per run
DT_K, 32'h0000_0086, Q16.16 constant 2/(g*N_STEPS); dt = v0y*DT_K
WDOG_CYCLES, 4096, core_done timeout in clocks (used only with RK4_WDOG_EN)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
v0y_valid  in  1  one-cycle pulse: v0y_data holds a new launch velocity
v0y_data  in  32  signed Q16.16 v0y (m/s)
busy  out  1  high from accepted v0y until EOS word handshake completes
core_start  out  1  one-cycle pulse starting one RK4 step
core_dt  out  32  Q16.16 dt, stable for the whole run
core_t  out  32  Q16.16 current t, stable while the step is in flight
core_y  out  32  Q16.16 current y
core_vy  out  32  Q16.16 current vy
core_done  in  1  one-cycle pulse: core outputs valid
core_t_out, core_y_out, core_vy_out  in  32 each  post-step state
tx_valid  out  1  word available to serializer
tx_data  out  32  word to send (serializer sends little-endian bytes)
tx_ready  in  1  serializer accepts word when tx_valid&&tx_ready
step_cnt  out  8  steps completed in the current run

Behaviour:
- Reset (asynchronous, any state): state=IDLE; busy, core_start, tx_valid = 0; core_dt, core_t, core_y, core_vy, tx_data, step_cnt = 0.
- IDLE: on v0y_valid, latch v0y and go to CALC. busy rises next cycle.
- CALC (1 cycle): core_dt = (v0y*DT_K) >>> 16, using a 64-bit signed product truncated to 32 bits; t=0, y=0, vy=v0y, step_cnt=0. If v0y <= 0 go to EOS, else go to STEP.
- STEP: assert core_start for exactly 1 cycle, then go to WAIT.
- WAIT: hold core_* inputs. On core_done: capture the three outputs and increment step_cnt.
  - If core_y_out < 0 (sign bit set): discard the step, do not send, go to EOS.
  - Otherwise commit t/y/vy and go to SEND_T.
- SEND_T: tx_data = t, tx_valid = 1. On handshake go to SEND_Y.
- SEND_Y: tx_data = y, tx_valid = 1. On handshake: go to EOS if step_cnt == N_STEPS, else go to STEP.
- EOS: tx_data = 32'hDEADBEEF, tx_valid = 1. On handshake go to IDLE with busy = 0.
- Handshake rules:
  - tx_data must stay stable while tx_valid is high and tx_ready is low.
  - tx_valid must not drop before the handshake.
  - Back-to-back words are legal, one per cycle.
- v0y_valid while busy is ignored; there is no queueing.
- core_done outside WAIT is ignored.
- Latency from v0y_valid to the first core_start is 3 cycles.
- Worst-case run: N_STEPS pairs followed by EOS, i.e. 2*N_STEPS+1 words.

Optional Feature:
RK4_WDOG_EN
- Defined: a counter runs in WAIT. If it reaches WDOG_CYCLES without core_done, the controller sends 32'hBADC0DE0 and then EOS, and the core is not restarted. The counter clears on every core_start.
- Undefined: no counter; WAIT waits forever.

Decomposition:
- Package rk4_ctrl_pkg:
  - typedef q16_t (logic signed [31:0])
  - state enum
  - EOS_MARKER = 32'hDEADBEEF
  - WDOG_MARKER = 32'hBADC0DE0
  - DT_K default
- Sub-module q16_mul: signed Q16.16 multiply, 64-bit product >>>16, combinational; used for dt.

Test Plan:
- v0y=0x00310000 (49.0), tx_ready=1, model core -> core_dt=0x000019A6; pairs streamed until y<0 or 100 steps, then 0xDEADBEEF; busy falls after EOS.
- v0y=0x00139999 (19.6) -> core_dt=0x00000A42; first tx_data=t=0x00000A42; step_cnt increments per pair.
- v0y=0xFFFF0000 (-1.0) -> no core_start; single word 0xDEADBEEF.
- tx_ready toggled pseudo-randomly during the 9.8 m/s run -> tx_data stable under backpressure; no words lost or duplicated; word order ti, yi, ..., EOS.
- Core model returns y=-1 on step 7 -> 6 pairs sent, then EOS; step 7 data never appears on tx.
- rst_n low in WAIT at step 40, then v0y=49.0 -> all outputs at reset values; new run restarts at step_cnt=0; with RK4_WDOG_EN and core_done withheld -> 0xBADC0DE0 then 0xDEADBEEF after WDOG_CYCLES.
